store_queue_ctrl: RTL and testbench

- Buffers committed stores from the MEM stage in a small in-order queue and sequences them to the data memory write port over a req/ack handshake.
- Converts store type (sb/sh/sw) and address offset into a word-aligned address, lane-placed write data and a 4-bit byte enable.
- Flags misaligned stores and reports load/store word-address hazards to the hazard unit.

---
 rtl/store_queue_ctrl_pkg.sv | 25 ++
 rtl/store_lane_fmt.sv | 38 +++
 rtl/store_queue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_store_queue_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_ctrl_pkg.sv
// Shared types for the store queue: store-size encodings, queue entry layout
// and drain FSM states. Entry addresses are SQ_ADDR_W wide; the top's ADDR_W must match.
package store_queue_ctrl_pkg;

    localparam int SQ_ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_SB     = 2'b00,
        ST_SH     = 2'b01,
        ST_SW     = 2'b10,
        ST_SW_ALT = 2'b11
    } st_src_e;

    typedef struct packed {
        logic [SQ_ADDR_W-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           be;
    } sq_entry_t;

    typedef enum logic {
        SQ_IDLE = 1'b0,
        SQ_BUSY = 1'b1
    } sq_state_e;

endpackage

// File: rtl/store_lane_fmt.sv
// Combinational store formatter: alignment check, byte-enable generation and
// replication of the store data across the byte lanes it may land in.
module store_lane_fmt
    import store_queue_ctrl_pkg::*;
(
    input  logic [1:0]  store_src,
    input  logic [1:0]  offset,
    input  logic [31:0] write_data,
    output logic        aligned,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    // Size decode; the 2'b11 encoding falls into the word path.
    always_comb begin
        aligned = 1'b1;
        be      = 4'b1111;
        wdata   = write_data;
        case (st_src_e'(store_src))
            ST_SB: begin
                aligned = 1'b1;
                be      = 4'b0001 << offset;
                wdata   = {4{write_data[7:0]}};
            end
            ST_SH: begin
                aligned = (offset[0] == 1'b0);
                be      = 4'b0011 << offset;
                wdata   = {2{write_data[15:0]}};
            end
            default: begin
                aligned = (offset == 2'b00);
                be      = 4'b1111;
                wdata   = write_data;
            end
        endcase
    end

endmodule

// File: rtl/store_queue_ctrl.sv
// In-order store queue between MEM and the data-memory write port: formats and
// buffers stores, drains them over req/ack and flags load/store word hazards.
module store_queue_ctrl
    import store_queue_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SQ_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 store_src,
    input  logic [ADDR_W-1:0]          store_address,
    input  logic [31:0]                write_data,
    input  logic                       ld_check_valid,
    input  logic [ADDR_W-1:0]          ld_check_addr,
    output logic                       ld_hazard,
    output logic                       misalign_err,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    sq_entry_t          entries_q [DEPTH];
    sq_entry_t          entries_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    sq_state_e          state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic               misalign_q, misalign_d;

    logic               fmt_aligned_s;
    logic [3:0]         fmt_be_s;
    logic [31:0]        fmt_wdata_s;
    logic               push_s, pop_s, reject_s;
    logic               addr_match_s;
    logic [1:0]         ld_addr_unused_s;

    store_lane_fmt u_lane_fmt (
        .store_src  (store_src),
        .offset     (store_address[1:0]),
        .write_data (write_data),
        .aligned    (fmt_aligned_s),
        .be         (fmt_be_s),
        .wdata      (fmt_wdata_s)
    );

    assign st_ready         = (count_q != CNT_FULL);
    assign push_s           = st_valid && st_ready && fmt_aligned_s;
    assign reject_s         = st_valid && st_ready && !fmt_aligned_s;
    assign pop_s            = (state_q == SQ_BUSY) && mem_ack;
    assign ld_addr_unused_s = ld_check_addr[1:0];

    // Queue storage, pointers and occupancy; the in-flight head stays counted until acked.
    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_s) begin
            entries_d[wr_ptr_q].addr  = {store_address[ADDR_W-1:2], 2'b00};
            entries_d[wr_ptr_q].wdata = fmt_wdata_s;
            entries_d[wr_ptr_q].be    = fmt_be_s;
            valid_d[wr_ptr_q]         = 1'b1;
            wr_ptr_d                  = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: latch the head onto the write port, hold it until the ack.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        misalign_d  = reject_s;
        case (state_q)
            SQ_IDLE: begin
                if (count_q != {CNT_W{1'b0}}) begin
                    state_d     = SQ_BUSY;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = entries_q[rd_ptr_q].addr;
                    mem_wdata_d = entries_q[rd_ptr_q].wdata;
                    mem_be_d    = entries_q[rd_ptr_q].be;
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            SQ_BUSY: begin
                if (mem_ack) begin
                    state_d   = SQ_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d   = SQ_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Word-address match of the load against every occupied entry.
    always_comb begin
        addr_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries_q[i].addr[ADDR_W-1:2] == ld_check_addr[ADDR_W-1:2])) begin
                addr_match_s = 1'b1;
            end else begin
                addr_match_s = addr_match_s;
            end
        end
    end

    // State registers with synchronous reset; an outstanding write is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q     <= {DEPTH{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            state_q     <= SQ_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            misalign_q  <= 1'b0;
        end else begin
            entries_q   <= entries_d;
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            misalign_q  <= misalign_d;
        end
    end

    assign ld_hazard    = ld_check_valid && addr_match_s;
    assign misalign_err = misalign_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_be       = mem_be_q;
    assign count        = count_q;
    assign empty        = (count_q == {CNT_W{1'b0}}) && !mem_req_q;

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Scoreboard bench for store_queue_ctrl: stimulus pushes expected memory writes,
// a monitor pops and compares each new write request the DUT presents.
module tb_store_queue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  store_src;
    logic [31:0] store_address;
    logic [31:0] write_data;
    logic        ld_check_valid;
    logic [31:0] ld_check_addr;
    logic        ld_hazard;
    logic        misalign_err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [2:0]  count;
    logic        empty;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [67:0] exp_q [$];
    bit          ack_auto = 1'b0;
    int          tokens_given = 0;
    int          tokens_used = 0;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    store_queue_ctrl #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .store_src      (store_src),
        .store_address  (store_address),
        .write_data     (write_data),
        .ld_check_valid (ld_check_valid),
        .ld_check_addr  (ld_check_addr),
        .ld_hazard      (ld_hazard),
        .misalign_err   (misalign_err),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_be         (mem_be),
        .mem_ack        (mem_ack),
        .count          (count),
        .empty          (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stimulus acts 1 time unit after the falling edge, after monitor and responder.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] src, input logic [31:0] a, input logic [31:0] d,
                         input bit exp_acc, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        st_valid      = 1'b1;
        store_src     = src;
        store_address = a;
        write_data    = d;
        if (exp_acc) exp_q.push_back({exp_addr, exp_wdata, exp_be});
        step();
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!(empty === 1'b1 && exp_q.size() == 0) && n < 200) begin
            step();
            n++;
        end
        chk({name, "_drained"}, {67'd0, (empty === 1'b1 && exp_q.size() == 0)}, 68'd1);
    endtask

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        while (mem_ack !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_ack_seen"}, {67'd0, mem_ack}, 68'd1);
    endtask

    task automatic wait_count0(input string name);
        int n;
        n = 0;
        while (count !== 3'd0 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_count0"}, {65'd0, count}, 68'd0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (st_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_ready"}, {67'd0, st_ready}, 68'd1);
    endtask

    // Memory responder: fixed grants via tokens, or automatic with random delay 0-3.
    initial begin : responder
        int wait_cnt;
        int cur_delay;
        wait_cnt  = 0;
        cur_delay = 0;
        mem_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req === 1'b1) begin
                if (ack_auto) begin
                    if (wait_cnt >= cur_delay) begin
                        mem_ack   = 1'b1;
                        wait_cnt  = 0;
                        cur_delay = $urandom_range(0, 3);
                    end else begin
                        wait_cnt++;
                    end
                end else if (tokens_given > tokens_used) begin
                    mem_ack = 1'b1;
                    tokens_used++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every rising mem_req is a new write and must match the scoreboard head.
    initial begin : monitor
        logic        req_prev;
        logic [67:0] exp_w;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && req_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h be %b, expected no write",
                             mem_addr, mem_wdata, mem_be);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("mem_write", {mem_addr, mem_wdata, mem_be}, exp_w);
                end
            end
            req_prev = mem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset          = 1'b1;
        st_valid       = 1'b0;
        store_src      = SW;
        store_address  = 32'h0;
        write_data     = 32'h0;
        ld_check_valid = 1'b0;
        ld_check_addr  = 32'h0;
        step();
        step();
        reset = 1'b0;
        chk("rst_count", {65'd0, count}, 68'd0);
        chk("rst_empty", {67'd0, empty}, 68'd1);
        chk("rst_req", {67'd0, mem_req}, 68'd0);
        chk("rst_ready", {67'd0, st_ready}, 68'd1);
        chk("rst_misalign", {67'd0, misalign_err}, 68'd0);
        chk("rst_mem_out", {mem_addr, mem_wdata, mem_be}, 68'd0);

        // 1: reset while a write is outstanding
        store(SW, 32'h100, 32'hDEADBEEF, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
        chk("t1_count", {65'd0, count}, 68'd1);
        chk("t1_req_latency", {67'd0, mem_req}, 68'd0);
        step();
        chk("t1_req", {67'd0, mem_req}, 68'd1);
        chk("t1_not_empty", {67'd0, empty}, 68'd0);
        reset = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b0;
        chk("t1_req_after_rst", {67'd0, mem_req}, 68'd0);
        chk("t1_count_after_rst", {65'd0, count}, 68'd0);
        chk("t1_empty_after_rst", {67'd0, empty}, 68'd1);
        chk("t1_mem_after_rst", {mem_addr, mem_wdata, mem_be}, 68'd0);
        for (int i = 0; i < 4; i++) step();
        chk("t1_no_reissue", {67'd0, mem_req}, 68'd0);

        // 2: lane formatting
        ack_auto = 1'b1;
        store(SB, 32'h203, 32'h000000A5, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b1000);
        store(SH, 32'h202, 32'h00001234, 1'b1, 32'h200, 32'h12341234, 4'b1100);
        wait_empty("t2");

        // 3: full queue and backpressure
        ack_auto = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready_before", {67'd0, st_ready}, (i < 4) ? 68'd1 : 68'd0);
            store(SW, 32'(4 * i), 32'h1000 + 32'(i), (i < 4), 32'(4 * i), 32'h1000 + 32'(i), 4'b1111);
        end
        chk("t3_count_full", {65'd0, count}, 68'd4);
        chk("t3_ready_full", {67'd0, st_ready}, 68'd0);
        tokens_given++;
        wait_ack("t3");
        chk("t3_ready_during_pop", {67'd0, st_ready}, 68'd0);
        step();
        chk("t3_count_after_pop", {65'd0, count}, 68'd3);
        chk("t3_ready_after_pop", {67'd0, st_ready}, 68'd1);
        ack_auto = 1'b1;
        wait_empty("t3");

        // 4: misalignment
        store(SW, 32'h102, 32'h11111111, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t4_sw_misalign", {67'd0, misalign_err}, 68'd1);
        chk("t4_sw_count", {65'd0, count}, 68'd0);
        step();
        chk("t4_sw_pulse_end", {67'd0, misalign_err}, 68'd0);
        store(SH, 32'h101, 32'h22222222, 1'b0, 32'h0, 32'h0, 4'b0000);
        chk("t4_sh_misalign", {67'd0, misalign_err}, 68'd1);
        chk("t4_sh_count", {65'd0, count}, 68'd0);
        step();
        chk("t4_sh_pulse_end", {67'd0, misalign_err}, 68'd0);
        store(SB, 32'h101, 32'h0000005A, 1'b1, 32'h100, 32'h5A5A5A5A, 4'b0010);
        chk("t4_sb_no_err", {67'd0, misalign_err}, 68'd0);
        chk("t4_sb_count", {65'd0, count}, 68'd1);
        wait_empty("t4");

        // 5: load hazard
        ack_auto = 1'b0;
        store(SW, 32'h40, 32'h33333333, 1'b1, 32'h40, 32'h33333333, 4'b1111);
        ld_check_valid = 1'b1;
        ld_check_addr  = 32'h43;
        #1;
        chk("t5_haz_queued", {67'd0, ld_hazard}, 68'd1);
        ld_check_addr = 32'h44;
        #1;
        chk("t5_haz_other_word", {67'd0, ld_hazard}, 68'd0);
        ld_check_valid = 1'b0;
        ld_check_addr  = 32'h43;
        #1;
        chk("t5_haz_no_load", {67'd0, ld_hazard}, 68'd0);
        ld_check_valid = 1'b1;
        step();
        chk("t5_haz_inflight", {67'd0, ld_hazard}, 68'd1);
        tokens_given++;
        wait_count0("t5");
        chk("t5_haz_after_pop", {67'd0, ld_hazard}, 68'd0);
        ld_check_valid = 1'b0;
        wait_empty("t5");

        // 6: simultaneous push/pop, then wrap with random ack delays
        store(SW, 32'h500, 32'hA0000000, 1'b1, 32'h500, 32'hA0000000, 4'b1111);
        store(SW, 32'h504, 32'hA0000001, 1'b1, 32'h504, 32'hA0000001, 4'b1111);
        chk("t6_count_before", {65'd0, count}, 68'd2);
        tokens_given++;
        wait_ack("t6");
        store(SW, 32'h508, 32'hA0000002, 1'b1, 32'h508, 32'hA0000002, 4'b1111);
        chk("t6_count_pushpop", {65'd0, count}, 68'd2);
        ack_auto = 1'b1;
        wait_empty("t6a");
        for (int i = 0; i < 10; i++) begin
            wait_ready("t6_wrap");
            store(SW, 32'h600 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b1,
                  32'h600 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'b1111);
        end
        wait_empty("t6b");
        chk("scoreboard_empty", {36'd0, 32'(exp_q.size())}, 68'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
